rf_write_arb: RTL and testbench
===============================

RF_WRITE_ARB -- requirements
Module: rf_write_arb

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port ValidA, input, 1: requester A (ALU writeback) holds a write.
REQ-004 SHALL have port AddrA, input, 4: destination register for A.
REQ-005 SHALL have port DataA, input, 32: write data for A.
REQ-006 SHALL have port ReadyA, output, 1: A's write is accepted this cycle.
REQ-007 SHALL have ports ValidB, AddrB, DataB and ReadyB, identical to the A ports, for requester B (load writeback).
REQ-008 SHALL have port Hold, input, 1: when high, blocks all grants.
REQ-009 SHALL have port RF_we, output, 1: active-high write enable to the register-file write port.
REQ-010 SHALL have port RF_wa, output, 4: register-file write address.
REQ-011 SHALL have port RF_wd, output, 32: register-file write data.
REQ-012 SHALL have port LastGnt, output, 1: most recent grant (0=A, 1=B).

Function
REQ-013 SHALL treat a transfer as having occurred for requester X in cycle N when ValidX=1 and ReadyX=1 at the rising edge ending cycle N.
REQ-014 SHALL compute ReadyA and ReadyB combinationally from ValidA, ValidB, Hold and LastGnt.
- At most one of ReadyA and ReadyB is 1 in any cycle.
- ReadyX is 0 whenever ValidX=0.
REQ-015 SHALL assert both ReadyA and ReadyB as 0 while Hold=1 or Reset=1.
REQ-016 SHALL grant a lone valid requester (only one of ValidA/ValidB high, Hold=0) in that same cycle.
REQ-017 SHALL resolve both-valid (Hold=0) round-robin.
- The requester not equal to LastGnt is granted.
- The other requester sees Ready=0 and SHALL keep Valid, Addr and Data stable until it is granted.
REQ-018 SHALL update LastGnt to the granted requester at the edge of each transfer, and leave it unchanged otherwise.
REQ-019 SHALL register the output stage.
- A transfer in cycle N drives RF_we=1, RF_wa=the granted Addr and RF_wd=the granted Data throughout cycle N+1.
- Latency is exactly 1 cycle.
REQ-020 SHALL drive RF_we=0 in any cycle N+1 that follows a cycle N with no transfer; RF_wa and RF_wd then hold their previous values.
REQ-021 SHALL sustain one write per cycle; back-to-back transfers produce RF_we=1 in consecutive cycles.
REQ-022 SHALL handle both-valid with AddrA==AddrB as ordinary arbitration.
- Two separate writes are issued, in grant order.
- The second-granted data is the final register content.
REQ-023 SHALL still complete the output-stage write in cycle N+1 when Hold rises in cycle N+1 after a transfer in cycle N; Hold blocks only new grants.
REQ-024 SHALL never drop, duplicate or reorder an accepted write.

Reset
REQ-025 SHALL, on a rising edge with Reset=1, set RF_we=0, RF_wa=4'h0, RF_wd=32'h0 and LastGnt=1 (so A wins the first contention).
REQ-026 SHALL discard an output-stage write pending from the cycle in which Reset is asserted; RF_we is 0 in the following cycle.

Configuration
REQ-027 SHALL honour macro RF_ARB_FIXED_PRIO_EN.
- Defined: both-valid always grants A; LastGnt still tracks grants per REQ-018.
- Undefined: round-robin per REQ-017.
- All other behaviour is identical in both builds.

Verification
REQ-028 SHALL cover lone A: Reset cycle, then ValidA=1, AddrA=4'h3, DataA=100 for one cycle -> ReadyA=1 that cycle; next cycle RF_we=1, RF_wa=3, RF_wd=100; the cycle after, RF_we=0.
REQ-029 SHALL cover contention after reset: ValidA=ValidB=1 (A: r5/104, B: r9/35) held until granted -> cycle 0 ReadyA=1; cycle 1 ReadyB=1 with RF_we write r5=104; cycle 2 RF_we write r9=35; LastGnt=1 at end.
REQ-030 SHALL cover sustained contention: both valid for 6 cycles with fresh data each grant -> grants alternate A,B,A,B,A,B and RF_we=1 for 6 consecutive cycles (round-robin build); A,A,A,... with B starved (RF_ARB_FIXED_PRIO_EN build).
REQ-031 SHALL cover Hold: ValidB=1 with Hold=1 for 3 cycles -> ReadyB=0 and RF_we=0 throughout; Hold drops -> ReadyB=1 that cycle, write appears the next cycle.
REQ-032 SHALL cover Reset mid-operation: transfer A (r2/44) in cycle N with Reset=1 in cycle N -> RF_we=0 in N+1 and LastGnt=1.
REQ-033 SHALL cover same-address contention: A and B both target r7 (A=8, B=12) -> two writes in order A then B; the register-file read of r7 afterwards returns 12.

Source files
------------

// File: rtl/rf_write_arb.sv
// rtl/rf_write_arb.sv - two-requester register-file write-port arbiter
//
// Purpose:
//   Arbitrates the single register-file write port between requester A
//   (ALU writeback) and requester B (load writeback). Grants are decided
//   combinationally in the request cycle; the granted write is registered
//   and presented to the register file in the following cycle.
//
// Configuration:
//   RF_ARB_FIXED_PRIO_EN - when defined, A always wins contention.
//                          When undefined, contention is round-robin.
//
// Ports:
//   Clk            in   1   clock, all state on rising edge
//   Reset          in   1   synchronous, active-high
//   ValidA/ValidB  in   1   requester holds a write
//   AddrA/AddrB    in   4   destination register
//   DataA/DataB    in  32   write data
//   ReadyA/ReadyB  out  1   write accepted this cycle
//   Hold           in   1   blocks all new grants
//   RF_we          out  1   register-file write enable
//   RF_wa          out  4   register-file write address
//   RF_wd          out 32   register-file write data
//   LastGnt        out  1   most recent grant (0=A, 1=B)

module rf_write_arb (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidA,
  input  logic [3:0]  AddrA,
  input  logic [31:0] DataA,
  output logic        ReadyA,
  input  logic        ValidB,
  input  logic [3:0]  AddrB,
  input  logic [31:0] DataB,
  output logic        ReadyB,
  input  logic        Hold,
  output logic        RF_we,
  output logic [3:0]  RF_wa,
  output logic [31:0] RF_wd,
  output logic        LastGnt
);

  logic        r_we;
  logic [3:0]  r_wa;
  logic [31:0] r_wd;
  logic        r_last;

  logic        w_block;
  logic        w_pick_b;
  logic        w_gnt_a;
  logic        w_gnt_b;

  // Reset also blocks grants so no write can be accepted and then lost.
  assign w_block = Hold | Reset;

`ifdef RF_ARB_FIXED_PRIO_EN
  // B only wins when A is idle.
  assign w_pick_b = ValidB & ~ValidA;
`else
  // B wins when alone, or on contention when A was granted last.
  assign w_pick_b = ValidB & (~ValidA | ~r_last);
`endif

  assign w_gnt_b = ~w_block & w_pick_b;
  assign w_gnt_a = ~w_block & ValidA & ~w_pick_b;

  assign ReadyA  = w_gnt_a;
  assign ReadyB  = w_gnt_b;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_we   <= 1'b0;
      r_wa   <= 4'h0;
      r_wd   <= 32'h0;
      r_last <= 1'b1;
    end else begin
      r_we <= w_gnt_a | w_gnt_b;
      if (w_gnt_a) begin
        r_wa   <= AddrA;
        r_wd   <= DataA;
        r_last <= 1'b0;
      end else if (w_gnt_b) begin
        r_wa   <= AddrB;
        r_wd   <= DataB;
        r_last <= 1'b1;
      end
    end
  end

  assign RF_we   = r_we;
  assign RF_wa   = r_wa;
  assign RF_wd   = r_wd;
  assign LastGnt = r_last;

endmodule

// File: tb/tb_rf_write_arb.sv
// tb/tb_rf_write_arb.sv - randomized and directed bench for rf_write_arb

module tb_rf_write_arb;

  logic        Clk = 1'b0;
  logic        Reset, ValidA, ValidB, Hold;
  logic [3:0]  AddrA, AddrB;
  logic [31:0] DataA, DataB;
  logic        ReadyA, ReadyB, RF_we, LastGnt;
  logic [3:0]  RF_wa;
  logic [31:0] RF_wd;

  rf_write_arb dut (
    .Clk(Clk), .Reset(Reset),
    .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
    .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
    .Hold(Hold), .RF_we(RF_we), .RF_wa(RF_wa), .RF_wd(RF_wd),
    .LastGnt(LastGnt)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file attached to the write port.
  logic [31:0] tb_rf [16];
  int          n_wr = 0;
  always @(posedge Clk) begin
    if (RF_we === 1'b1) begin
      tb_rf[RF_wa] <= RF_wd;
      n_wr         <= n_wr + 1;
    end
  end

  // Stimulus state: each requester holds a pending write until accepted.
  bit          pa = 0, pb = 0;
  logic [3:0]  aa = 0, ab = 0;
  logic [31:0] da = 0, db = 0;
  bit          hold = 0, rst = 0;
  int          p_new = 0;

  // Reference model: expected output stage and arbitration history.
  bit          m_ok = 0;
  bit          m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_last;
  int          n_acc = 0;
  int          gnt_log[$];

  task automatic cycle();
    bit ga, gb;
    @(negedge Clk);
    if (!pa && $urandom_range(99) < p_new) begin
      pa = 1; aa = 4'($urandom_range(15)); da = $urandom;
    end
    if (!pb && $urandom_range(99) < p_new) begin
      pb = 1; ab = 4'($urandom_range(15)); db = $urandom;
    end
    ValidA = pa; AddrA = aa; DataA = da;
    ValidB = pb; AddrB = ab; DataB = db;
    Hold = hold; Reset = rst;
    #1;
    ga = 0; gb = 0;
    if (!rst && !hold) begin
      if (pa && pb) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        ga = 1;
`else
        // The requester that did not win last time goes first.
        if (m_last) ga = 1; else gb = 1;
`endif
      end else begin
        ga = pa; gb = pb;
      end
    end
    check("ReadyA", 32'(ReadyA), 32'(ga));
    check("ReadyB", 32'(ReadyB), 32'(gb));
    if (m_ok) begin
      check("RF_we", 32'(RF_we), 32'(m_we));
      check("RF_wa", 32'(RF_wa), 32'(m_wa));
      check("RF_wd", RF_wd, m_wd);
      check("LastGnt", 32'(LastGnt), 32'(m_last));
    end
    @(posedge Clk);
    if (rst) begin
      m_ok = 1; m_we = 0; m_wa = 0; m_wd = 0; m_last = 1;
    end else begin
      m_we = ga || gb;
      if (ga) begin
        m_wa = aa; m_wd = da; m_last = 0; pa = 0; n_acc++; gnt_log.push_back(0);
      end else if (gb) begin
        m_wa = ab; m_wd = db; m_last = 1; pb = 0; n_acc++; gnt_log.push_back(1);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    Reset = 1; ValidA = 0; ValidB = 0; Hold = 0;
    AddrA = 0; AddrB = 0; DataA = 0; DataB = 0;
    do_reset();
    do_reset();

    // Lone A write to r3.
    pa = 1; aa = 4'h3; da = 32'd100;
    cycle(); cycle(); cycle();
    #2;
    check("lone_rf3", tb_rf[3], 32'd100);

    // Contention straight after reset.
    do_reset();
    gnt_log.delete();
    pa = 1; aa = 4'h5; da = 32'd104;
    pb = 1; ab = 4'h9; db = 32'd35;
    cycle(); cycle(); cycle(); cycle();
    #2;
    check("cont_rf5", tb_rf[5], 32'd104);
    check("cont_rf9", tb_rf[9], 32'd35);
    check("cont_last", 32'(LastGnt), 32'd1);
    check("cont_order", 32'(gnt_log.size() == 2 && gnt_log[0] == 0 && gnt_log[1] == 1), 32'd1);

    // Sustained contention with fresh data after every grant.
    do_reset();
    gnt_log.delete();
    p_new = 100;
    for (int i = 0; i < 6; i++) cycle();
    p_new = 0; pa = 0; pb = 0;
    cycle(); cycle();
    for (int i = 0; i < 6; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      check("sustain_gnt", 32'(gnt_log[i]), 32'd0);
`else
      check("sustain_gnt", 32'(gnt_log[i]), 32'(i % 2));
`endif
    end

    // Hold blocks B for three cycles.
    do_reset();
    gnt_log.delete();
    pb = 1; ab = 4'hc; db = 32'hdead_beef;
    hold = 1;
    cycle(); cycle(); cycle();
    check("hold_nogrant", 32'(gnt_log.size()), 32'd0);
    hold = 0;
    cycle(); cycle(); cycle();
    #2;
    check("hold_rfc", tb_rf[12], 32'hdead_beef);

    // Reset arriving in the same cycle as an A request.
    pa = 1; aa = 4'h1; da = 32'd7;
    cycle(); cycle();
    pa = 1; aa = 4'h2; da = 32'd44;
    rst = 1; cycle(); rst = 0;
    #1;
    check("rst_we", 32'(RF_we), 32'd0);
    check("rst_last", 32'(LastGnt), 32'd1);
    pa = 0;
    cycle();

    // Same destination register from both requesters.
    do_reset();
    pa = 1; aa = 4'h7; da = 32'd8;
    pb = 1; ab = 4'h7; db = 32'd12;
    cycle(); cycle(); cycle(); cycle();
    #2;
    check("same_rf7", tb_rf[7], 32'd12);

    // Random traffic with occasional Hold and Reset.
    p_new = 60;
    for (int i = 0; i < 2000; i++) begin
      hold = ($urandom_range(4) == 0);
      rst  = ($urandom_range(49) == 0);
      cycle();
    end
    hold = 0; rst = 0; p_new = 0;
    for (int i = 0; i < 5; i++) cycle();
    #2;
    check("write_count", 32'(n_wr), 32'(n_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
